lsu_mem_master: RTL and testbench
=================================

// Module: lsu_mem_master
// PURPOSE
//  Load/store initiator that drives the CPU's simple physical-memory port (ren/raddr/rdata, wen/waddr/wdata/wmask).
//  Accepts one load/store at a time from the LSU over a valid/ready request channel.
//  Performs the single memory access, then returns the aligned, extended result over a valid/ready response channel.
//  Sits between the LSU/EXU and the DPI-backed memory model.
// PARAMETERS
//  WAIT_CYCLES  0   extra idle cycles between request accept and the memory access (latency emulation), 0..15
//  ADDR_W       32  address width; data width fixed at 32
// PORTS
//  clock         in   1       system clock
//  reset         in   1       asynchronous, active-low reset
//  req_valid     in   1       request valid
//  req_ready     out  1       request ready (high only in IDLE)
//  req_wen       in   1       1=store, 0=load
//  req_addr      in   ADDR_W  byte address
//  req_wdata     in   32      store data, right-aligned
//  req_size      in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1       load zero-extends when 1, sign-extends when 0
//  rsp_valid     out  1       response valid
//  rsp_ready     in   1       response accept
//  rsp_rdata     out  32      extended load data; 0 for stores
//  rsp_err       out  1       access fault (only with MISALIGN_TRAP_EN)
//  mem_ren       out  1       memory read strobe
//  mem_raddr     out  ADDR_W  word-aligned read address
//  mem_rdata     in   32      read data, valid before the posedge that ends the ren cycle
//  mem_wen       out  1       memory write strobe, committed at posedge
//  mem_waddr     out  ADDR_W  word-aligned write address
//  mem_wdata     out  32      lane-shifted store data
//  mem_wmask     out  4       byte-lane mask
// BEHAVIOUR
//  FSM states: IDLE, WAIT, ACCESS, RESP. State flops and the output flops use async reset.
//  Reset asserted:
//   - state=IDLE; counter=0.
//   - All outputs 0, including req_ready.
//   - Any in-flight op is abandoned; mem_wen drops immediately, so no write occurs unless its posedge already passed.
//  IDLE:
//   - req_ready=1.
//   - On req_valid&req_ready, latch wen/addr/wdata/size/unsigned.
//   - Next state is WAIT (counter=WAIT_CYCLES) if WAIT_CYCLES>0, else ACCESS.
//  WAIT: counter decrements each cycle; go to ACCESS when it reaches 1.
//  ACCESS: exactly one cycle.
//   - Common: off=addr[1:0]; address driven = {addr[ADDR_W-1:2],2'b00}.
//   - Load: mem_ren=1.
//   - Store: mem_wen=1; mem_wdata=wdata<<(8*off); mem_wmask=base<<off, where base is 0001/0011/1111 for b/h/w.
//   - Store result: rsp_rdata=0.
//   - At the closing posedge: rsp_rdata = ext(mem_rdata>>(8*off), size, unsigned); then go to RESP.
//   - mem_ren and mem_wen are never high together, and are never high outside ACCESS.
//  RESP:
//   - rsp_valid=1; rsp_rdata and rsp_err held stable.
//   - On rsp_ready, go to IDLE and clear rsp_valid. No request overlap.
//  Latency: accept at edge N, ACCESS during cycle N+1+WAIT_CYCLES, rsp_valid from cycle N+2+WAIT_CYCLES.
//  rsp_ready high before RESP is ignored. req_valid outside IDLE is ignored.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   - Faulting requests: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
//   - A faulting request bypasses WAIT/ACCESS and enters RESP the cycle after accept, with rsp_err=1 and rsp_rdata=0.
//   - No memory strobe is issued for it.
//  MISALIGN_TRAP_EN undefined:
//   - rsp_err tied 0.
//   - Offset truncated: half uses {addr[1],1'b0}; word uses 0.
//   - size=11 is treated as word.
// TESTING
//  1. reset low 3 cycles mid-store -> all outputs 0, no mem_wen; release -> req_ready=1 next cycle.
//  2. sw 0xDEADBEEF @0x80000004, WAIT_CYCLES=0 -> one cycle mem_wen=1, waddr 0x80000004, wmask 1111; rsp_valid 2 cycles after accept.
//  3. lb @0x80000003, mem_rdata=0x80FF1234 -> rsp_rdata 0xFFFFFF80; lbu -> 0x00000080; lh @0x80000002 -> 0xFFFF80FF.
//  4. sh 0x0000ABCD @0x80000002 -> mem_wdata 0xABCD0000, mem_wmask 1100.
//  5. WAIT_CYCLES=3, lw; rsp_ready low 5 cycles -> ACCESS 4 cycles after accept; rsp_valid/rsp_rdata stable, req_ready=0, no strobes.
//  6. lw @0x80000001: with MISALIGN_TRAP_EN -> rsp_err=1, no mem_ren; without -> mem_raddr 0x80000000, rsp_err=0.

Source files
------------

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator for the CPU's simple
// physical-memory port. Accepts one request, optionally idles WAIT_CYCLES cycles,
// performs one memory access and returns the aligned, extended result.
//
// Ports:
//   clock, reset (async, active-low)
//   req_*  : valid/ready request channel from the LSU (store flag, address, data, size, unsigned)
//   rsp_*  : valid/ready response channel (extended load data, access fault)
//   mem_*  : memory read strobe/address/data and write strobe/address/data/byte mask
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned and size=11 requests
// (rsp_err=1, no memory access). Without it rsp_err is 0, misaligned offsets are
// truncated and size=11 behaves as a word access.
module lsu_mem_master #(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;

    // Latched request fields
    logic               lat_wen;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic [1:0]         lat_size;
    logic               lat_unsigned;

    // Operation currently being set up: live request in IDLE, latched copy afterwards
    logic               op_wen;
    logic [ADDR_W-1:0]  op_addr;
    logic [DATA_W-1:0]  op_wdata;
    logic [1:0]         op_size;
    logic               op_unsigned;

    logic               accept;
    logic               fault;
    logic [1:0]         off;
    logic [3:0]         base_mask;
    logic [ADDR_W-1:0]  aligned_addr;
    logic [DATA_W-1:0]  rd_shift;

    logic               req_ready_nxt;
    logic               rsp_valid_nxt;
    logic [DATA_W-1:0]  rsp_rdata_nxt;
    logic               rsp_err_nxt;
    logic               mem_ren_nxt;
    logic [ADDR_W-1:0]  mem_raddr_nxt;
    logic               mem_wen_nxt;
    logic [ADDR_W-1:0]  mem_waddr_nxt;
    logic [DATA_W-1:0]  mem_wdata_nxt;
    logic [3:0]         mem_wmask_nxt;

    // Sign/zero extension of right-aligned load data
    function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] d,
                                                   input logic [1:0] size,
                                                   input logic uns);
        logic [DATA_W-1:0] r;
        case (size)
            2'b00:   r = uns ? {24'h0, d[7:0]}   : {{24{d[7]}}, d[7:0]};
            2'b01:   r = uns ? {16'h0, d[15:0]}  : {{16{d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign accept = req_valid && req_ready && (state == S_IDLE);

`ifdef MISALIGN_TRAP_EN
    assign fault = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign fault = 1'b0;
`endif

    assign op_wen      = (state == S_IDLE) ? req_wen      : lat_wen;
    assign op_addr     = (state == S_IDLE) ? req_addr     : lat_addr;
    assign op_wdata    = (state == S_IDLE) ? req_wdata    : lat_wdata;
    assign op_size     = (state == S_IDLE) ? req_size     : lat_size;
    assign op_unsigned = (state == S_IDLE) ? req_unsigned : lat_unsigned;

    // Lane offset; misaligned bits are dropped (only reachable when not trapping)
    always_comb begin
        off       = 2'b00;
        base_mask = 4'b1111;
        case (op_size)
            2'b00: begin
                off       = op_addr[1:0];
                base_mask = 4'b0001;
            end
            2'b01: begin
                off       = {op_addr[1], 1'b0};
                base_mask = 4'b0011;
            end
            default: begin
                off       = 2'b00;
                base_mask = 4'b1111;
            end
        endcase
    end

    assign aligned_addr = {op_addr[ADDR_W-1:2], 2'b00};
    assign rd_shift     = mem_rdata >> {off, 3'b000};

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (fault) begin
                        state_nxt = S_RESP;
                    end else if (WAIT_CYCLES > 0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_W'(WAIT_CYCLES);
                    end else begin
                        state_nxt = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = S_ACCESS;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        req_ready_nxt = (state_nxt == S_IDLE);
        rsp_valid_nxt = (state_nxt == S_RESP);
        mem_ren_nxt   = (state_nxt == S_ACCESS) && !op_wen;
        mem_wen_nxt   = (state_nxt == S_ACCESS) && op_wen;
        mem_raddr_nxt = mem_ren_nxt ? aligned_addr : '0;
        mem_waddr_nxt = mem_wen_nxt ? aligned_addr : '0;
        mem_wdata_nxt = mem_wen_nxt ? (op_wdata << {off, 3'b000}) : '0;
        mem_wmask_nxt = mem_wen_nxt ? (base_mask << off) : 4'b0000;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        if (state == S_ACCESS) begin
            rsp_rdata_nxt = op_wen ? '0 : load_ext(rd_shift, op_size, op_unsigned);
            rsp_err_nxt   = 1'b0;
        end else if (accept && fault) begin
            rsp_rdata_nxt = '0;
            rsp_err_nxt   = 1'b1;
        end
    end

    // Output registers; reset drops any pending strobe immediately
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_ren   <= 1'b0;
            mem_raddr <= '0;
            mem_wen   <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            mem_wmask <= 4'b0000;
        end else begin
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
            mem_ren   <= mem_ren_nxt;
            mem_raddr <= mem_raddr_nxt;
            mem_wen   <= mem_wen_nxt;
            mem_waddr <= mem_waddr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_wmask <= mem_wmask_nxt;
        end
    end

    // Request capture on accept
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_wen      <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
        end else if (accept) begin
            lat_wen      <= req_wen;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: a WAIT_CYCLES=0 instance driven from a vector table
// with a strobe/response scoreboard, and a WAIT_CYCLES=3 instance driven by a
// hand-written cycle-by-cycle sequence. Honors MISALIGN_TRAP_EN if defined.
module tb_lsu_mem_master;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned NV     = 13;

    logic              clock;
    logic              reset;

    // Instance with WAIT_CYCLES=0
    logic              req_valid, req_ready, req_wen, req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_size;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [31:0]       rsp_rdata;
    logic              mem_ren, mem_wen;
    logic [ADDR_W-1:0] mem_raddr, mem_waddr;
    logic [31:0]       mem_rdata, mem_wdata, mem_word;
    logic [3:0]        mem_wmask;

    // Instance with WAIT_CYCLES=3
    logic              b_req_valid, b_req_ready, b_req_wen, b_req_unsigned;
    logic [ADDR_W-1:0] b_req_addr;
    logic [31:0]       b_req_wdata;
    logic [1:0]        b_req_size;
    logic              b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0]       b_rsp_rdata;
    logic              b_mem_ren, b_mem_wen;
    logic [ADDR_W-1:0] b_mem_raddr, b_mem_waddr;
    logic [31:0]       b_mem_rdata, b_mem_wdata, b_word;
    logic [3:0]        b_mem_wmask;

    assign mem_rdata   = mem_ren   ? mem_word : 32'h0;
    assign b_mem_rdata = b_mem_ren ? b_word   : 32'h0;

    lsu_mem_master #(.WAIT_CYCLES(0), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
    );

    lsu_mem_master #(.WAIT_CYCLES(3), .ADDR_W(ADDR_W)) dut_w3 (
        .clock(clock), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_size(b_req_size),
        .req_unsigned(b_req_unsigned),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .mem_ren(b_mem_ren), .mem_raddr(b_mem_raddr), .mem_rdata(b_mem_rdata),
        .mem_wen(b_mem_wen), .mem_waddr(b_mem_waddr), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] word;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_maddr;
        logic [31:0] exp_mwdata;
        logic [3:0]  exp_mask;
    } vec_t;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } mem_exp_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_exp_t;

    vec_t     vecs [NV];
    mem_exp_t mem_q[$];
    rsp_exp_t rsp_q[$];
    int       n_checks;
    int       n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic any_out_a();
        return |{req_ready, rsp_valid, rsp_rdata, rsp_err, mem_ren, mem_raddr,
                 mem_wen, mem_waddr, mem_wdata, mem_wmask};
    endfunction

    function automatic logic any_out_b();
        return |{b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err, b_mem_ren, b_mem_raddr,
                 b_mem_wen, b_mem_waddr, b_mem_wdata, b_mem_wmask};
    endfunction

    // Scoreboard for the WAIT_CYCLES=0 instance
    always @(negedge clock) begin : monitor
        mem_exp_t me;
        rsp_exp_t re;
        if (reset) begin
            check("strobe_exclusive", {31'b0, mem_ren & mem_wen}, 32'h0);
            if (mem_ren || mem_wen) begin
                if (mem_q.size() == 0) begin
                    check("unexpected_strobe", {30'b0, mem_ren, mem_wen}, 32'h0);
                end else begin
                    me = mem_q.pop_front();
                    check("strobe_kind", {31'b0, mem_wen}, {31'b0, me.wen});
                    if (me.wen) begin
                        check("mem_waddr", mem_waddr, me.addr);
                        check("mem_wdata", mem_wdata, me.wdata);
                        check("mem_wmask", {28'b0, mem_wmask}, {28'b0, me.mask});
                    end else begin
                        check("mem_raddr", mem_raddr, me.addr);
                    end
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", {31'b0, rsp_valid}, 32'h0);
                end else begin
                    re = rsp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, re.rdata);
                    check("rsp_err", {31'b0, rsp_err}, {31'b0, re.err});
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int guard;
        int lat;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        req_valid = 0; req_wen = 0; req_addr = '0; req_wdata = '0; req_size = 0; req_unsigned = 0;
        rsp_ready = 0; mem_word = '0;
        b_req_valid = 0; b_req_wen = 0; b_req_addr = '0; b_req_wdata = '0; b_req_size = 0;
        b_req_unsigned = 0; b_rsp_ready = 0; b_word = '0;

        //            wen addr          wdata         sz    uns word          rdata         err  maddr         mwdata        mask
        vecs[0]  = '{1'b1, 32'h80000004, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        32'h0,        1'b0, 32'h80000004, 32'hDEADBEEF, 4'hF};
        vecs[1]  = '{1'b0, 32'h80000003, 32'h0,        2'd0, 1'b0, 32'h80FF1234, 32'hFFFFFF80, 1'b0, 32'h80000000, 32'h0,        4'h0};
        vecs[2]  = '{1'b0, 32'h80000003, 32'h0,        2'd0, 1'b1, 32'h80FF1234, 32'h00000080, 1'b0, 32'h80000000, 32'h0,        4'h0};
        vecs[3]  = '{1'b0, 32'h80000002, 32'h0,        2'd1, 1'b0, 32'h80FF1234, 32'hFFFF80FF, 1'b0, 32'h80000000, 32'h0,        4'h0};
        vecs[4]  = '{1'b1, 32'h80000002, 32'h0000ABCD, 2'd1, 1'b0, 32'h0,        32'h0,        1'b0, 32'h80000000, 32'hABCD0000, 4'hC};
        vecs[5]  = '{1'b0, 32'h80000001, 32'h0,        2'd2, 1'b0, 32'h12345678, 32'h12345678, 1'b0, 32'h80000000, 32'h0,        4'h0};
        vecs[6]  = '{1'b0, 32'h80000000, 32'h0,        2'd1, 1'b1, 32'h80FF1234, 32'h00001234, 1'b0, 32'h80000000, 32'h0,        4'h0};
        vecs[7]  = '{1'b1, 32'h80000001, 32'h123456A5, 2'd0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h80000000, 32'h3456A500, 4'h2};
        vecs[8]  = '{1'b0, 32'h80000001, 32'h0,        2'd0, 1'b0, 32'h80FF1234, 32'h00000012, 1'b0, 32'h80000000, 32'h0,        4'h0};
        vecs[9]  = '{1'b0, 32'h80000000, 32'h0,        2'd3, 1'b0, 32'hCAFEBABE, 32'hCAFEBABE, 1'b0, 32'h80000000, 32'h0,        4'h0};
        vecs[10] = '{1'b1, 32'h80000003, 32'h00001234, 2'd1, 1'b0, 32'h0,        32'h0,        1'b0, 32'h80000000, 32'h12340000, 4'hC};
        vecs[11] = '{1'b0, 32'h80000001, 32'h0,        2'd1, 1'b0, 32'h80FF1234, 32'h00001234, 1'b0, 32'h80000000, 32'h0,        4'h0};
        vecs[12] = '{1'b0, 32'h8000010E, 32'h0,        2'd1, 1'b0, 32'h9ABC5678, 32'hFFFF9ABC, 1'b0, 32'h8000010C, 32'h0,        4'h0};
`ifdef MISALIGN_TRAP_EN
        for (int i = 0; i < NV; i++) begin
            if ((vecs[i].size == 2'd3) ||
                ((vecs[i].size == 2'd1) && vecs[i].addr[0]) ||
                ((vecs[i].size == 2'd2) && (vecs[i].addr[1:0] != 2'b00))) begin
                vecs[i].exp_rdata = 32'h0;
                vecs[i].exp_err   = 1'b1;
            end
        end
`endif

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_outputs_w0", {31'b0, any_out_a()}, 32'h0);
        check("reset_outputs_w3", {31'b0, any_out_b()}, 32'h0);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("ready_after_release", {31'b0, req_ready}, 32'h1);
        check("ready_after_release_w3", {31'b0, b_req_ready}, 32'h1);

        // Reset in the middle of a store: strobe must drop at once
        @(posedge clock); #1;
        req_valid = 1; req_wen = 1; req_addr = 32'h80000010; req_wdata = 32'h55AA55AA; req_size = 2'd2;
        @(posedge clock); #2;
        check("midstore_wen_before_reset", {31'b0, mem_wen}, 32'h1);
        reset = 1'b0;
        #1;
        check("midstore_outputs_now", {31'b0, any_out_a()}, 32'h0);
        req_valid = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("midstore_outputs_held", {31'b0, any_out_a()}, 32'h0);
        end
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("ready_after_midstore_reset", {31'b0, req_ready}, 32'h1);
        check("no_wen_after_midstore_reset", {31'b0, mem_wen}, 32'h0);
        @(posedge clock); #1;

        // Table-driven requests on the WAIT_CYCLES=0 instance
        for (int i = 0; i < NV; i++) begin
            guard = 0;
            while (!req_ready && guard < 20) begin
                @(posedge clock); #1;
                guard++;
            end
            check("req_ready_wait", {31'b0, req_ready}, 32'h1);
            req_wen = vecs[i].wen; req_addr = vecs[i].addr; req_wdata = vecs[i].wdata;
            req_size = vecs[i].size; req_unsigned = vecs[i].uns; mem_word = vecs[i].word;
            req_valid = 1;
            @(posedge clock);
            if (!vecs[i].exp_err)
                mem_q.push_back('{vecs[i].wen, vecs[i].exp_maddr, vecs[i].exp_mwdata, vecs[i].exp_mask});
            rsp_q.push_back('{vecs[i].exp_rdata, vecs[i].exp_err});
            #1 req_valid = 0;
            lat = 0;
            do begin
                @(negedge clock);
                lat++;
            end while (!rsp_valid && lat < 10);
            check("rsp_latency", lat, vecs[i].exp_err ? 32'd1 : 32'd2);
            for (int k = 0; k < i % 3; k++) begin
                @(negedge clock);
                check("rsp_hold_valid", {31'b0, rsp_valid}, 32'h1);
                check("rsp_hold_rdata", rsp_rdata, vecs[i].exp_rdata);
            end
            @(posedge clock); #1 rsp_ready = 1;
            @(posedge clock); #1 rsp_ready = 0;
        end

        // WAIT_CYCLES=3 load with stalled response; stray req_valid/rsp_ready ignored
        @(negedge clock);
        check("w3_ready_idle", {31'b0, b_req_ready}, 32'h1);
        @(posedge clock); #1;
        b_req_valid = 1; b_req_wen = 0; b_req_addr = 32'h80000008; b_req_size = 2'd2;
        b_req_unsigned = 0; b_word = 32'h11223344; b_rsp_ready = 1;
        @(posedge clock); #1;
        b_req_addr = 32'h90000000;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            check("w3_mem_ren", {31'b0, b_mem_ren}, (k == 4) ? 32'h1 : 32'h0);
            check("w3_mem_wen", {31'b0, b_mem_wen}, 32'h0);
            check("w3_req_ready", {31'b0, b_req_ready}, 32'h0);
            check("w3_rsp_valid", {31'b0, b_rsp_valid}, (k >= 5) ? 32'h1 : 32'h0);
            if (k == 4) check("w3_mem_raddr", b_mem_raddr, 32'h80000008);
            if (k >= 5) begin
                check("w3_rsp_rdata", b_rsp_rdata, 32'h11223344);
                check("w3_rsp_err", {31'b0, b_rsp_err}, 32'h0);
            end
            if (k == 3) b_rsp_ready = 0;
        end
        b_req_valid = 0;
        b_rsp_ready = 1;
        @(negedge clock);
        check("w3_rsp_done", {31'b0, b_rsp_valid}, 32'h0);
        check("w3_ready_again", {31'b0, b_req_ready}, 32'h1);
        b_rsp_ready = 0;

        repeat (3) @(negedge clock);
        check("mem_queue_empty", mem_q.size(), 32'd0);
        check("rsp_queue_empty", rsp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
